// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC sequencer and its datapath.
// Holds the default tap count and the 3-bit sequencer state encodings.
// No ports: this is a package.
package fir_pkg;

  // Default tap count, shared with the FIR datapath so both sides agree.
  localparam int NTAPS_DEFAULT = 8;

  // Sequencer state encodings. The remaining codes (5..7) are unused and
  // are recovered to ST_IDLE.
  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_MAC  = 3'd2;
  localparam logic [2:0] ST_DUMP = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Bundle of signals between the FIR MAC sequencer and its neighbours.
// Signals carried:
//   in_valid/in_ready       sample handshake with the source
//   x_we/x_zero/x_waddr     history RAM write port control
//   x_raddr/c_raddr         history RAM / coefficient ROM read addresses
//   acc_clr/acc_en/y_ld     accumulator and output register strobes
//   out_valid/out_ready     result handshake with the sink
//   busy                    sequencer is not idle
// Modports: master = sequencer side, slave = source/sink/datapath side.
interface fir_mac_sequencer_if #(
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic          x_we;
  logic          x_zero;
  logic [AW-1:0] x_waddr;
  logic [AW-1:0] x_raddr;
  logic [AW-1:0] c_raddr;
  logic          acc_clr;
  logic          acc_en;
  logic          y_ld;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport master (
    input  in_valid, out_ready,
    output in_ready, x_we, x_zero, x_waddr, x_raddr, c_raddr,
           acc_clr, acc_en, y_ld, out_valid, busy
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, x_we, x_zero, x_waddr, x_raddr, c_raddr,
           acc_clr, acc_en, y_ld, out_valid, busy
  );
endinterface

// File: rtl/fir_tap_addr.sv
// Combinational history read address for tap k: (newest - k) mod NTAPS.
// NTAPS need not be a power of two.
// Ports:
//   i_newest  in  AW  slot holding the current sample
//   i_k       in  AW  tap index, 0..NTAPS-1
//   o_raddr   out AW  slot holding the sample k steps older
module fir_tap_addr #(
  parameter int NTAPS = 8,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic [AW-1:0] i_newest,
  input  logic [AW-1:0] i_k,
  output logic [AW-1:0] o_raddr
);
  // NTAPS reduced modulo 2^AW. For a power-of-two NTAPS this is zero, which
  // is still right: the true result is below NTAPS, so wrapping AW-bit
  // arithmetic yields it exactly.
  localparam logic [AW-1:0] NT_MOD = AW'(NTAPS);

  // Subtract directly when no wrap is needed, otherwise add NTAPS back.
  always_comb begin
    if (i_k <= i_newest) begin
      o_raddr = i_newest - i_k;
    end else begin
      o_raddr = i_newest + (NT_MOD - i_k);
    end
  end
endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a time-multiplexed single-MAC FIR with NTAPS taps.
// Zero-fills the circular history after reset, accepts one sample per
// handshake, steps history/coefficient addresses through all taps while
// the accumulator runs, loads the output register and holds out_valid
// until the sink takes the result.
// Ports:
//   i_clk    in  1   clock, rising edge
//   i_reset  in  1   synchronous reset, active-low (0 = reset)
//   io_seq   master side of fir_mac_sequencer_if (handshakes + strobes)
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEFAULT,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  fir_mac_sequencer_if.master io_seq
);
  localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
  localparam logic [AW-1:0] ZERO_A   = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_A    = AW'(1);

  logic [2:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_newest;
  logic [AW-1:0] r_k;

  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_tap_raddr;
  logic          w_accept;
  logic          w_in_ready;
  logic          w_x_we;
  logic          w_x_zero;
  logic [AW-1:0] w_x_waddr;
  logic [AW-1:0] w_x_raddr;
  logic [AW-1:0] w_c_raddr;
  logic          w_acc_clr;
  logic          w_acc_en;
  logic          w_y_ld;
  logic          w_out_valid;
  logic          w_busy;

  fir_tap_addr #(.NTAPS(NTAPS), .AW(AW)) u_tap_addr (
    .i_newest (r_newest),
    .i_k      (r_k),
    .o_raddr  (w_tap_raddr)
  );

  // Next history write slot, wrapping at NTAPS rather than at 2^AW.
  always_comb begin
    if (r_wr_ptr == LAST_TAP) begin
      w_wr_ptr_nxt = ZERO_A;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr + ONE_A;
    end
  end

  // Output decode from state registers plus in_valid/out_ready.
  // in_ready is a function of state and out_ready only, never in_valid.
  always_comb begin
    w_accept    = 1'b0;
    w_in_ready  = 1'b0;
    w_x_we      = 1'b0;
    w_x_zero    = 1'b0;
    w_x_waddr   = ZERO_A;
    w_x_raddr   = ZERO_A;
    w_c_raddr   = ZERO_A;
    w_acc_clr   = 1'b0;
    w_acc_en    = 1'b0;
    w_y_ld      = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_busy    = 1'b1;
        w_x_we    = 1'b1;
        w_x_zero  = 1'b1;
        w_x_waddr = r_k;
      end
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (io_seq.in_valid) begin
          w_accept  = 1'b1;
          w_x_we    = 1'b1;
          w_x_waddr = r_wr_ptr;
          w_acc_clr = 1'b1;
        end else begin
          w_accept  = 1'b0;
        end
      end
      ST_MAC: begin
        w_busy    = 1'b1;
        w_acc_en  = 1'b1;
        w_c_raddr = r_k;
        w_x_raddr = w_tap_raddr;
      end
      ST_DUMP: begin
        w_busy = 1'b1;
        w_y_ld = 1'b1;
      end
      ST_HOLD: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        w_in_ready  = io_seq.out_ready;
        // Result leaves and a new sample enters in the same cycle.
        if (io_seq.out_ready && io_seq.in_valid) begin
          w_accept  = 1'b1;
          w_x_we    = 1'b1;
          w_x_waddr = r_wr_ptr;
          w_acc_clr = 1'b1;
        end else begin
          w_accept  = 1'b0;
        end
      end
      default: begin
        // Unused encodings look idle but accept nothing.
        w_busy = 1'b0;
      end
    endcase
  end

  // State, pointer and tap counter updates with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= ST_INIT;
      r_wr_ptr <= ZERO_A;
      r_newest <= ZERO_A;
      r_k      <= ZERO_A;
    end else if (w_accept) begin
      r_state  <= ST_MAC;
      r_newest <= r_wr_ptr;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_k      <= ZERO_A;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_k == LAST_TAP) begin
            r_state <= ST_IDLE;
            r_k     <= ZERO_A;
          end else begin
            r_k <= r_k + ONE_A;
          end
        end
        ST_IDLE: r_state <= ST_IDLE;
        ST_MAC: begin
          if (r_k == LAST_TAP) begin
            r_state <= ST_DUMP;
            r_k     <= ZERO_A;
          end else begin
            r_k <= r_k + ONE_A;
          end
        end
        ST_DUMP: r_state <= ST_HOLD;
        ST_HOLD: begin
          if (io_seq.out_ready) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_seq.in_ready  = w_in_ready;
  assign io_seq.x_we      = w_x_we;
  assign io_seq.x_zero    = w_x_zero;
  assign io_seq.x_waddr   = w_x_waddr;
  assign io_seq.x_raddr   = w_x_raddr;
  assign io_seq.c_raddr   = w_c_raddr;
  assign io_seq.acc_clr   = w_acc_clr;
  assign io_seq.acc_en    = w_acc_en;
  assign io_seq.y_ld      = w_y_ld;
  assign io_seq.out_valid = w_out_valid;
  assign io_seq.busy      = w_busy;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: an 8-tap instance with a behavioural
// datapath (history RAM, coefficient ROM, MAC, y register) and a 5-tap
// instance for non-power-of-two wrap addressing.
module tb_fir_mac_sequencer;
  logic clk;
  logic rst_n;
  int   x_data;
  int   n_vec;
  int   n_err;
  bit   auto_ref;
  int   sb[$];

  // strobe pack: {in_ready, x_we, x_zero, acc_clr, acc_en, y_ld, out_valid, busy}
  localparam logic [7:0] S_INIT  = 8'b0110_0001;
  localparam logic [7:0] S_IDLE  = 8'b1000_0000;
  localparam logic [7:0] S_ACC   = 8'b1101_0000;
  localparam logic [7:0] S_MAC   = 8'b0000_1001;
  localparam logic [7:0] S_DUMP  = 8'b0000_0101;
  localparam logic [7:0] S_HOLDR = 8'b1000_0011;
  localparam logic [7:0] S_HOLDS = 8'b0000_0011;
  localparam logic [7:0] S_HACC  = 8'b1101_0011;

  fir_mac_sequencer_if #(.AW(3)) bus8 ();
  fir_mac_sequencer_if #(.AW(3)) bus5 ();

  fir_mac_sequencer #(.NTAPS(8)) u_dut8 (.i_clk(clk), .i_reset(rst_n), .io_seq(bus8));
  fir_mac_sequencer #(.NTAPS(5)) u_dut5 (.i_clk(clk), .i_reset(rst_n), .io_seq(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath for the 8-tap instance, coefficients 1..8.
  int hist_m [8];
  int coef_rom [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int acc_m = 0;
  int y_m   = 0;

  always @(posedge clk) begin
    if (bus8.x_we) hist_m[bus8.x_waddr] <= bus8.x_zero ? 0 : x_data;
    if (bus8.acc_clr) acc_m <= 0;
    else if (bus8.acc_en) acc_m <= acc_m + hist_m[bus8.x_raddr] * coef_rom[bus8.c_raddr];
    if (bus8.y_ld) y_m <= acc_m;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] st8();
    return {bus8.in_ready, bus8.x_we, bus8.x_zero, bus8.acc_clr,
            bus8.acc_en, bus8.y_ld, bus8.out_valid, bus8.busy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops on every result handshake; in reference mode
  // it also pushes a direct-form FIR result for each accepted sample.
  initial begin : monitor
    int ref_hist [8];
    int e;
    int s;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        for (int j = 0; j < 8; j++) ref_hist[j] = 0;
      end else begin
        if (bus8.out_valid && bus8.out_ready) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got result %0d, expected no result", y_m);
          end else begin
            e = sb.pop_front();
            if (y_m != e) begin
              n_err++;
              $display("FAIL sb_result: got %0d expected %0d at %0t", y_m, e, $time);
            end
          end
        end
        if (auto_ref && bus8.in_valid && bus8.in_ready) begin
          for (int j = 7; j > 0; j--) ref_hist[j] = ref_hist[j-1];
          ref_hist[0] = x_data;
          s = 0;
          for (int j = 0; j < 8; j++) s += ref_hist[j] * coef_rom[j];
          sb.push_back(s);
        end
      end
    end
  end

  // Eight zero-fill cycles, then idle.
  task automatic init_check(input string tag);
    for (int j = 0; j < 8; j++) begin
      chk({tag, "_init_strobes"}, st8(), S_INIT);
      chk({tag, "_init_waddr"}, bus8.x_waddr, j);
      step();
    end
    bus8.in_valid = 1'b0;
    #1;
    chk({tag, "_idle"}, st8(), S_IDLE);
  endtask

  // Accept from IDLE; exp_y < 0 means the result will be dropped.
  task automatic accept8(input int val, input int waddr, input int exp_y);
    bus8.in_valid = 1'b1;
    x_data = val;
    #1;
    chk("acc_strobes", st8(), S_ACC);
    chk("acc_waddr", bus8.x_waddr, waddr);
    if (exp_y >= 0) sb.push_back(exp_y);
    step();
    bus8.in_valid = 1'b0;
    #1;
  endtask

  task automatic mac_check(input int newest, input int nk);
    for (int k = 0; k < nk; k++) begin
      chk("mac_strobes", st8(), S_MAC);
      chk("mac_c_raddr", bus8.c_raddr, k);
      chk("mac_x_raddr", bus8.x_raddr, (newest - k + 8) % 8);
      step();
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int wa5 [7] = '{0, 1, 2, 3, 4, 0, 1};
    int ra5 [5] = '{1, 0, 4, 3, 2};
    int w;
    int n_acc;
    int cyc;
    n_vec = 0;
    n_err = 0;
    auto_ref = 1'b0;
    x_data = 0;
    rst_n = 1'b0;
    bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b1;
    bus5.in_valid = 1'b0;
    bus5.out_ready = 1'b1;

    // Reset held 3 cycles with in_valid high, then zero-fill.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_strobes", st8(), S_INIT);
      chk("rst_waddr", bus8.x_waddr, 0);
    end
    rst_n = 1'b1;
    #1;
    init_check("rst");

    // Single sample 10: y = 10*1.
    accept8(10, 0, 10);
    mac_check(0, 8);
    chk("single_dump", st8(), S_DUMP);
    step();
    chk("single_hold", st8(), S_HOLDR);
    step();
    chk("single_after", st8(), S_IDLE);

    // Reset at k=3: result dropped, zero-fill repeats, wr_ptr back to 0.
    accept8(7, 1, -1);
    mac_check(1, 3);
    chk("midrst_k3", st8(), S_MAC);
    chk("midrst_c3", bus8.c_raddr, 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    init_check("midrst");

    // Sample 5 on zero history; backpressure for 20 cycles.
    bus8.out_ready = 1'b0;
    accept8(5, 0, 5);
    mac_check(0, 8);
    chk("bp_dump", st8(), S_DUMP);
    step();
    bus8.in_valid = 1'b1;
    x_data = 4;
    #1;
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold", st8(), S_HOLDS);
      step();
    end
    // Same-cycle consume + accept of 4: y = 4*1 + 5*2 = 14.
    bus8.out_ready = 1'b1;
    #1;
    chk("bp_hacc_strobes", st8(), S_HACC);
    chk("bp_hacc_waddr", bus8.x_waddr, 1);
    sb.push_back(14);
    step();
    bus8.in_valid = 1'b0;
    #1;
    mac_check(1, 8);
    chk("bp_dump2", st8(), S_DUMP);
    step();
    chk("bp_hold2", st8(), S_HOLDR);
    step();
    chk("bp_idle", st8(), S_IDLE);

    // 5-tap wrap: write slots 0,1,2,3,4,0,1; last sample reads 1,0,4,3,2.
    for (int i = 0; i < 7; i++) begin
      w = 0;
      while (!bus5.in_ready && w < 50) begin
        step();
        w++;
      end
      chk("wrap_ready", bus5.in_ready, 1);
      bus5.in_valid = 1'b1;
      #1;
      chk("wrap_waddr", bus5.x_waddr, wa5[i]);
      chk("wrap_we", bus5.x_we, 1);
      step();
      bus5.in_valid = 1'b0;
      #1;
      if (i == 6) begin
        for (int k = 0; k < 5; k++) begin
          chk("wrap_raddr", bus5.x_raddr, ra5[k]);
          chk("wrap_acc_en", bus5.acc_en, 1);
          step();
        end
      end
    end

    // Random handshakes over 1000 samples against a direct-form FIR.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    auto_ref = 1'b1;
    w = 0;
    while (!bus8.in_ready && w < 20) begin
      step();
      w++;
    end
    chk("rand_start_ready", bus8.in_ready, 1);
    n_acc = 0;
    cyc = 0;
    while (n_acc < 1000 && cyc < 40000) begin
      bus8.in_valid = ($urandom_range(0, 3) != 0);
      x_data = $urandom_range(0, 255);
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus8.in_valid && bus8.in_ready) n_acc++;
      step();
      cyc++;
    end
    chk("rand_accepts", n_acc, 1000);
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      step();
      w++;
    end
    chk("rand_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
